// File: rtl/aes_dual_mode_ctrl.sv
// Request-queuing front end for one AES cipher core and one inverse cipher core.
// Tagged enc/dec requests are queued, dispatched in order and answered in order.
module aes_dual_mode_ctrl #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_mode,
  input  logic [127:0]     req_key,
  input  logic [127:0]     req_text,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_mode,
  output logic [127:0]     rsp_text,
  output logic [TAG_W-1:0] rsp_tag,
  input  logic             key_flush,
  output logic             busy,
  output logic             enc_ld,
  output logic [127:0]     enc_key,
  output logic [127:0]     enc_text_in,
  input  logic             enc_done,
  input  logic [127:0]     enc_text_out,
  output logic             dec_kld,
  output logic             dec_ld,
  output logic [127:0]     dec_key,
  output logic [127:0]     dec_text_in,
  input  logic             dec_kdone,
  input  logic             dec_done,
  input  logic [127:0]     dec_text_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENC_RUN,
    S_DEC_KEXP,
    S_DEC_RUN,
    S_RSP
  } state_t;

  state_t r_state;

  logic             r_mem_mode [DEPTH];
  logic [127:0]     r_mem_key  [DEPTH];
  logic [127:0]     r_mem_text [DEPTH];
  logic [TAG_W-1:0] r_mem_tag  [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;

  logic             r_mode;
  logic [127:0]     r_key;
  logic [127:0]     r_text;
  logic [TAG_W-1:0] r_tag;

  logic             r_kc_valid;
  logic [127:0]     r_kc_key;

  logic             r_rsp_valid;
  logic             r_rsp_mode;
  logic [127:0]     r_rsp_text;
  logic [TAG_W-1:0] r_rsp_tag;
  logic             r_enc_ld;
  logic             r_dec_kld;
  logic             r_dec_ld;

  logic w_push;
  logic w_pop;
  logic w_hit;

  assign req_ready = (r_cnt != FULL);
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == S_IDLE) && (r_cnt != '0);
  assign w_hit     = r_kc_valid && (r_kc_key == r_mem_key[r_rptr]);

  assign busy        = (r_state != S_IDLE) || (r_cnt != '0);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_mode    = r_rsp_mode;
  assign rsp_text    = r_rsp_text;
  assign rsp_tag     = r_rsp_tag;
  assign enc_ld      = r_enc_ld;
  assign dec_kld     = r_dec_kld;
  assign dec_ld      = r_dec_ld;
  assign enc_key     = r_key;
  assign enc_text_in = r_text;
  assign dec_key     = r_key;
  assign dec_text_in = r_text;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_mode[r_wptr] <= req_mode;
      r_mem_key[r_wptr]  <= req_key;
      r_mem_text[r_wptr] <= req_text;
      r_mem_tag[r_wptr]  <= req_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  // A flush in the same cycle as kdone must leave the cache invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kc_valid <= 1'b0;
      r_kc_key   <= '0;
    end else begin
      if (r_state == S_DEC_KEXP && dec_kdone) begin
        r_kc_valid <= 1'b1;
        r_kc_key   <= r_key;
      end
      if (key_flush) r_kc_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_key       <= '0;
      r_text      <= '0;
      r_tag       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_mode  <= 1'b0;
      r_rsp_text  <= '0;
      r_rsp_tag   <= '0;
      r_enc_ld    <= 1'b0;
      r_dec_kld   <= 1'b0;
      r_dec_ld    <= 1'b0;
    end else begin
      r_enc_ld  <= 1'b0;
      r_dec_kld <= 1'b0;
      r_dec_ld  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_mode <= r_mem_mode[r_rptr];
            r_key  <= r_mem_key[r_rptr];
            r_text <= r_mem_text[r_rptr];
            r_tag  <= r_mem_tag[r_rptr];
            if (!r_mem_mode[r_rptr]) begin
              r_state  <= S_ENC_RUN;
              r_enc_ld <= 1'b1;
            end else if (w_hit) begin
              r_state  <= S_DEC_RUN;
              r_dec_ld <= 1'b1;
            end else begin
              r_state   <= S_DEC_KEXP;
              r_dec_kld <= 1'b1;
            end
          end
        end
        S_ENC_RUN: begin
          if (enc_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_mode  <= r_mode;
            r_rsp_text  <= enc_text_out;
            r_rsp_tag   <= r_tag;
            r_state     <= S_RSP;
          end
        end
        S_DEC_KEXP: begin
          if (dec_kdone) begin
            r_state  <= S_DEC_RUN;
            r_dec_ld <= 1'b1;
          end
        end
        S_DEC_RUN: begin
          if (dec_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_mode  <= r_mode;
            r_rsp_text  <= dec_text_out;
            r_rsp_tag   <= r_tag;
            r_state     <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dual_mode_ctrl.sv
// Bench for aes_dual_mode_ctrl: behavioural cipher cores with random latency
// and an in-order scoreboard of expected responses.
module tb_aes_dual_mode_ctrl;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct packed {
    logic             mode;
    logic [127:0]     key;
    logic [127:0]     text;
    logic [TAG_W-1:0] tag;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic req_mode = 1'b0;
  logic [127:0] req_key = '0;
  logic [127:0] req_text = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic rsp_mode;
  logic [127:0] rsp_text;
  logic [TAG_W-1:0] rsp_tag;
  logic busy;
  logic enc_ld, dec_kld, dec_ld;
  logic [127:0] enc_key, enc_text_in, dec_key, dec_text_in;

  logic tb_flush = 1'b0;
  logic core_flush = 1'b0;
  logic tb_enc_done = 1'b0;
  logic core_enc_done = 1'b0;
  logic core_kdone = 1'b0;
  logic core_dec_done = 1'b0;
  logic [127:0] core_enc_text = '0;
  logic [127:0] core_dec_text = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit enc_hold = 1'b0;
  bit flush_with_kdone = 1'b0;

  int n_enc_ld = 0, n_kld = 0, n_dec_ld = 0;
  int last_enc_ld = -1, last_kld = -1, last_dec_ld = -1;
  int viol_width = 0;
  int unstable_e = 0, unstable_k = 0, unstable_d = 0;
  int enc_done_cyc = -1, kdone_cyc = -1, dec_done_cyc = -1;
  int ld_q[$];
  logic p_enc = 1'b0, p_kld = 1'b0, p_dec = 1'b0;

  aes_dual_mode_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mode     (req_mode),
    .req_key      (req_key),
    .req_text     (req_text),
    .req_tag      (req_tag),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_mode     (rsp_mode),
    .rsp_text     (rsp_text),
    .rsp_tag      (rsp_tag),
    .key_flush    (tb_flush | core_flush),
    .busy         (busy),
    .enc_ld       (enc_ld),
    .enc_key      (enc_key),
    .enc_text_in  (enc_text_in),
    .enc_done     (core_enc_done | tb_enc_done),
    .enc_text_out (core_enc_text),
    .dec_kld      (dec_kld),
    .dec_ld       (dec_ld),
    .dec_key      (dec_key),
    .dec_text_in  (dec_text_in),
    .dec_kdone    (core_kdone),
    .dec_done     (core_dec_done),
    .dec_text_out (core_dec_text)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in cipher: the FIPS-197 pair maps exactly, anything else is a
  // cheap invertible scramble so round trips stay checkable.
  function automatic logic [127:0] ref_enc(input logic [127:0] k, input logic [127:0] t);
    if (k == FK && t == FP) return FC;
    return {t[63:0], t[127:64]} ^ k;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] k, input logic [127:0] t);
    logic [127:0] x;
    if (k == FK && t == FC) return FP;
    x = t ^ k;
    return {x[63:0], x[127:64]};
  endfunction

  function automatic logic [127:0] ref_rsp(input req_t r);
    return r.mode ? ref_dec(r.key, r.text) : ref_enc(r.key, r.text);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (enc_ld) begin n_enc_ld++; last_enc_ld = cyc; ld_q.push_back(cyc); end
    if (dec_kld) begin n_kld++; last_kld = cyc; ld_q.push_back(cyc); end
    if (dec_ld) begin n_dec_ld++; last_dec_ld = cyc; ld_q.push_back(cyc); end
    if ((enc_ld && p_enc) || (dec_kld && p_kld) || (dec_ld && p_dec)) viol_width++;
    p_enc = enc_ld;
    p_kld = dec_kld;
    p_dec = dec_ld;
  end

  logic [127:0] ek, et, kk, dk, dt;

  always begin : enc_core
    @(negedge clk);
    if (enc_ld && !enc_hold) begin
      ek = enc_key;
      et = enc_text_in;
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        if (enc_key !== ek || enc_text_in !== et) unstable_e++;
      end
      core_enc_text = ref_enc(ek, et);
      core_enc_done = 1'b1;
      enc_done_cyc = cyc;
      @(negedge clk);
      core_enc_done = 1'b0;
    end
  end

  always begin : kexp_core
    @(negedge clk);
    if (dec_kld) begin
      kk = dec_key;
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        if (dec_key !== kk) unstable_k++;
      end
      core_kdone = 1'b1;
      core_flush = flush_with_kdone;
      kdone_cyc = cyc;
      @(negedge clk);
      core_kdone = 1'b0;
      core_flush = 1'b0;
    end
  end

  always begin : dec_core
    @(negedge clk);
    if (dec_ld) begin
      dk = dec_key;
      dt = dec_text_in;
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        if (dec_key !== dk || dec_text_in !== dt) unstable_d++;
      end
      core_dec_text = ref_dec(dk, dt);
      core_dec_done = 1'b1;
      dec_done_cyc = cyc;
      @(negedge clk);
      core_dec_done = 1'b0;
    end
  end

  // Called at a negedge; returns at a negedge after the handshake or timeout.
  task automatic send_req(input req_t r, input int maxc, output bit acc, output int n);
    req_valid = 1'b1;
    req_mode  = r.mode;
    req_key   = r.key;
    req_text  = r.text;
    req_tag   = r.tag;
    acc = 1'b0;
    n = -1;
    for (int i = 0; i < maxc && !acc; i++) begin
      if (req_ready) begin
        acc = 1'b1;
        n = cyc;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int maxc, output bit ok, output logic m,
                          output logic [127:0] t, output logic [TAG_W-1:0] g,
                          output int vc);
    ok = 1'b0;
    vc = -1;
    rsp_ready = 1'b1;
    for (int i = 0; i < maxc && !ok; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        m = rsp_mode;
        t = rsp_text;
        g = rsp_tag;
        vc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (ok) @(negedge clk);
  endtask

  task automatic do_one(input req_t r, output bit ok, output logic m,
                        output logic [127:0] t, output logic [TAG_W-1:0] g,
                        output int n, output int vc);
    bit acc;
    ok = 1'b0;
    send_req(r, 20, acc, n);
    if (acc) wait_rsp(100, ok, m, t, g, vc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid);
    end
    checks++;
    if ({enc_ld, dec_kld, dec_ld} !== 3'b000) begin
      errors++; $display("FAIL rst_pulses: got %b expected 000", {enc_ld, dec_kld, dec_ld});
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy: got %b expected 0", busy);
    end
    checks++;
    if ({rsp_text, enc_key, enc_text_in, dec_key, dec_text_in} !== '0) begin
      errors++; $display("FAIL rst_buses: got %h expected 0", rsp_text);
    end
    checks++;
    if ({rsp_mode, rsp_tag} !== '0) begin
      errors++; $display("FAIL rst_mode_tag: got %h expected 0", {rsp_mode, rsp_tag});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_req_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_fips_enc();
    req_t r;
    bit ok;
    logic m;
    logic [127:0] t;
    logic [TAG_W-1:0] g;
    int n, vc, be, bk, bd;
    be = n_enc_ld; bk = n_kld; bd = n_dec_ld;
    r = '{mode: 1'b0, key: FK, text: FP, tag: 4'd3};
    do_one(r, ok, m, t, g, n, vc);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL enc_done_timeout: got no response expected one");
    end
    checks++;
    if ({n_enc_ld - be, n_kld - bk, n_dec_ld - bd} !== {32'd1, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL enc_pulses: got enc=%0d kld=%0d dec=%0d expected 1/0/0",
               n_enc_ld - be, n_kld - bk, n_dec_ld - bd);
    end
    checks++;
    if (last_enc_ld !== n + 2) begin
      errors++; $display("FAIL enc_ld_cycle: got %0d expected %0d", last_enc_ld, n + 2);
    end
    checks++;
    if (vc !== enc_done_cyc + 1) begin
      errors++; $display("FAIL enc_rsp_latency: got %0d expected %0d", vc, enc_done_cyc + 1);
    end
    checks++;
    if (t !== FC) begin
      errors++; $display("FAIL enc_text: got %h expected %h", t, FC);
    end
    checks++;
    if ({m, g} !== {1'b0, 4'd3}) begin
      errors++; $display("FAIL enc_mode_tag: got %b/%0d expected 0/3", m, g);
    end
  endtask

  task automatic test_fips_dec_cold();
    req_t r;
    bit ok;
    logic m;
    logic [127:0] t;
    logic [TAG_W-1:0] g;
    int n, vc, be, bk, bd;
    be = n_enc_ld; bk = n_kld; bd = n_dec_ld;
    r = '{mode: 1'b1, key: FK, text: FC, tag: 4'd5};
    do_one(r, ok, m, t, g, n, vc);
    checks++;
    if ({n_enc_ld - be, n_kld - bk, n_dec_ld - bd} !== {32'd0, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL dec_pulses: got enc=%0d kld=%0d dec=%0d expected 0/1/1",
               n_enc_ld - be, n_kld - bk, n_dec_ld - bd);
    end
    checks++;
    if (last_kld !== n + 2) begin
      errors++; $display("FAIL dec_kld_cycle: got %0d expected %0d", last_kld, n + 2);
    end
    checks++;
    if (last_dec_ld !== kdone_cyc + 1) begin
      errors++; $display("FAIL dec_ld_after_kdone: got %0d expected %0d", last_dec_ld, kdone_cyc + 1);
    end
    checks++;
    if (!ok || t !== FP || m !== 1'b1 || g !== 4'd5) begin
      errors++; $display("FAIL dec_rsp: got ok=%0d %h/%b/%0d expected %h/1/5", ok, t, m, g, FP);
    end
  endtask

  task automatic test_key_cache();
    req_t r;
    bit ok;
    logic m;
    logic [127:0] t;
    logic [TAG_W-1:0] g;
    logic [127:0] k2;
    int n, vc, bk;
    bk = n_kld;
    r = '{mode: 1'b1, key: FK, text: rnd128(), tag: 4'd6};
    do_one(r, ok, m, t, g, n, vc);
    checks++;
    if (n_kld - bk !== 0 || last_dec_ld !== n + 2) begin
      errors++;
      $display("FAIL kc_hit: got kld=%0d dec_ld@%0d expected kld=0 dec_ld@%0d",
               n_kld - bk, last_dec_ld, n + 2);
    end
    checks++;
    if (!ok || t !== ref_rsp(r) || g !== r.tag) begin
      errors++; $display("FAIL kc_hit_rsp: got %h/%0d expected %h/%0d", t, g, ref_rsp(r), r.tag);
    end
    tb_flush = 1'b1;
    @(negedge clk);
    tb_flush = 1'b0;
    bk = n_kld;
    r = '{mode: 1'b1, key: FK, text: rnd128(), tag: 4'd7};
    do_one(r, ok, m, t, g, n, vc);
    checks++;
    if (n_kld - bk !== 1) begin
      errors++; $display("FAIL kc_flush: got kld=%0d expected 1", n_kld - bk);
    end
    k2 = rnd128();
    flush_with_kdone = 1'b1;
    bk = n_kld;
    r = '{mode: 1'b1, key: k2, text: rnd128(), tag: 4'd8};
    do_one(r, ok, m, t, g, n, vc);
    flush_with_kdone = 1'b0;
    checks++;
    if (!ok || n_kld - bk !== 1 || t !== ref_rsp(r) || g !== r.tag) begin
      errors++;
      $display("FAIL kc_coincident_op: got kld=%0d %h expected kld=1 %h", n_kld - bk, t, ref_rsp(r));
    end
    bk = n_kld;
    r = '{mode: 1'b1, key: k2, text: rnd128(), tag: 4'd9};
    do_one(r, ok, m, t, g, n, vc);
    checks++;
    if (n_kld - bk !== 1) begin
      errors++; $display("FAIL kc_flush_wins: got kld=%0d expected 1", n_kld - bk);
    end
  endtask

  task automatic test_backpressure();
    req_t exp_q[$];
    req_t r;
    bit acc;
    int n, accepted;
    logic [127:0] ct;
    logic [TAG_W-1:0] cg;
    logic cm;
    bit seen, back;
    rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      r.mode = $urandom_range(0, 1);
      r.key  = rnd128();
      r.text = rnd128();
      r.tag  = TAG_W'(i);
      send_req(r, 30, acc, n);
      if (acc) begin
        accepted++;
        exp_q.push_back(r);
      end
    end
    r = '{mode: 1'b0, key: rnd128(), text: rnd128(), tag: TAG_W'(DEPTH + 1)};
    send_req(r, 20, acc, n);
    if (acc) accepted++;
    checks++;
    if (accepted !== DEPTH + 1) begin
      errors++; $display("FAIL bp_accepted: got %0d expected %0d", accepted, DEPTH + 1);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full_ready: got %b expected 0", req_ready);
    end
    for (int j = 0; j <= DEPTH; j++) begin
      seen = 1'b0;
      for (int w = 0; w < 60 && !seen; w++) begin
        if (rsp_valid) seen = 1'b1;
        else @(negedge clk);
      end
      checks++;
      if (!seen) begin
        errors++; $display("FAIL bp_rsp_timeout: got no response expected tag %0d", j);
        break;
      end
      cm = rsp_mode; ct = rsp_text; cg = rsp_tag;
      r = exp_q.pop_front();
      checks++;
      if (cg !== TAG_W'(j) || ct !== ref_rsp(r) || cm !== r.mode) begin
        errors++;
        $display("FAIL bp_order: got tag %0d %h expected tag %0d %h", cg, ct, j, ref_rsp(r));
      end
      repeat (2) @(negedge clk);
      checks++;
      if (!rsp_valid || rsp_text !== ref_rsp(r) || rsp_tag !== r.tag || rsp_mode !== r.mode) begin
        errors++; $display("FAIL bp_stall_stable: got v=%b %h expected v=1 %h", rsp_valid, rsp_text, ref_rsp(r));
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      if (j == 0) begin
        back = 1'b0;
        for (int w = 0; w < 4 && !back; w++) begin
          @(negedge clk);
          if (req_ready) back = 1'b1;
        end
        checks++;
        if (!back) begin
          errors++; $display("FAIL bp_ready_return: got 0 expected 1");
        end
      end
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_mixed();
    req_t r;
    bit ok;
    logic m;
    logic [127:0] t;
    logic [TAG_W-1:0] g;
    int n, vc, be, bk, bd;
    tb_flush = 1'b1;
    @(negedge clk);
    tb_flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      r.mode = i[0];
      r.tag  = TAG_W'($urandom);
      if (i == 0) begin r.key = FK; r.text = FP; end
      else if (i == 1) begin r.key = FK; r.text = FC; end
      else begin r.key = rnd128(); r.text = rnd128(); end
      be = n_enc_ld; bk = n_kld; bd = n_dec_ld;
      do_one(r, ok, m, t, g, n, vc);
      checks++;
      if (!ok || t !== ref_rsp(r) || m !== r.mode || g !== r.tag) begin
        errors++;
        $display("FAIL mix_rsp[%0d]: got ok=%0d %h/%b/%0d expected %h/%b/%0d",
                 i, ok, t, m, g, ref_rsp(r), r.mode, r.tag);
      end
      checks++;
      if (r.mode ? ({n_enc_ld - be, n_kld - bk, n_dec_ld - bd} !== {32'd0, 32'd1, 32'd1})
                 : ({n_enc_ld - be, n_kld - bk, n_dec_ld - bd} !== {32'd1, 32'd0, 32'd0})) begin
        errors++;
        $display("FAIL mix_pulse[%0d]: got enc=%0d kld=%0d dec=%0d for mode %b",
                 i, n_enc_ld - be, n_kld - bk, n_dec_ld - bd, r.mode);
      end
    end
  endtask

  task automatic test_back_to_back();
    req_t rq[3];
    bit acc, ok;
    logic m;
    logic [127:0] t;
    logic [TAG_W-1:0] g;
    int n0, n, b;
    int vc[3];
    b = ld_q.size();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rq[i] = '{mode: 1'b0, key: rnd128(), text: rnd128(), tag: TAG_W'(10 + i)};
      send_req(rq[i], 20, acc, n);
      if (i == 0) n0 = n;
    end
    for (int i = 0; i < 3; i++) begin
      wait_rsp(100, ok, m, t, g, vc[i]);
      checks++;
      if (!ok || t !== ref_rsp(rq[i]) || g !== rq[i].tag) begin
        errors++; $display("FAIL b2b_rsp[%0d]: got %h/%0d expected %h/%0d", i, t, g, ref_rsp(rq[i]), rq[i].tag);
      end
    end
    checks++;
    if (ld_q.size() - b !== 3) begin
      errors++; $display("FAIL b2b_ld_count: got %0d expected 3", ld_q.size() - b);
    end else begin
      checks++;
      if (ld_q[b] !== n0 + 2) begin
        errors++; $display("FAIL b2b_first_ld: got %0d expected %0d", ld_q[b], n0 + 2);
      end
      checks++;
      if (ld_q[b + 1] !== vc[0] + 2 || ld_q[b + 2] !== vc[1] + 2) begin
        errors++;
        $display("FAIL b2b_next_ld: got %0d,%0d expected %0d,%0d",
                 ld_q[b + 1], ld_q[b + 2], vc[0] + 2, vc[1] + 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    req_t r;
    bit acc, ok, found, stray;
    logic m;
    logic [127:0] t;
    logic [TAG_W-1:0] g;
    int n, vc;
    enc_hold = 1'b1;
    rsp_ready = 1'b1;
    r = '{mode: 1'b0, key: rnd128(), text: rnd128(), tag: 4'hA};
    send_req(r, 20, acc, n);
    found = 1'b0;
    for (int w = 0; w < 10 && !found; w++) begin
      if (enc_ld) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rm_enc_ld: got none expected one");
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || {enc_ld, dec_kld, dec_ld} !== 3'b000) begin
      errors++; $display("FAIL rm_outputs: got busy=%b v=%b ld=%b expected 0/0/000",
                         busy, rsp_valid, {enc_ld, dec_kld, dec_ld});
    end
    checks++;
    if ({enc_key, enc_text_in} !== '0) begin
      errors++; $display("FAIL rm_buses: got %h expected 0", enc_key);
    end
    @(negedge clk);
    rst = 1'b0;
    tb_enc_done = 1'b1;
    @(negedge clk);
    tb_enc_done = 1'b0;
    stray = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid || busy) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++; $display("FAIL rm_no_rsp: got activity after late enc_done expected none");
    end
    enc_hold = 1'b0;
    r = '{mode: 1'b0, key: rnd128(), text: rnd128(), tag: 4'hB};
    do_one(r, ok, m, t, g, n, vc);
    checks++;
    if (!ok || t !== ref_rsp(r) || g !== 4'hB || m !== 1'b0) begin
      errors++; $display("FAIL rm_after: got ok=%0d %h/%0d expected %h/11", ok, t, g, ref_rsp(r));
    end
  endtask

  task automatic test_integrity();
    checks++;
    if (viol_width !== 0) begin
      errors++; $display("FAIL pulse_width: got %0d wide pulses expected 0", viol_width);
    end
    checks++;
    if (unstable_e + unstable_k + unstable_d !== 0) begin
      errors++;
      $display("FAIL operand_stable: got %0d/%0d/%0d changes expected 0",
               unstable_e, unstable_k, unstable_d);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fips_enc();
    test_fips_dec_cold();
    test_key_cache();
    test_backpressure();
    test_mixed();
    test_back_to_back();
    test_reset_mid();
    test_integrity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
